fifo_write_arbiter: RTL and testbench

//  Shares the write port of the async FIFO among NUM_REQ producers in the write clock domain.

---
 rtl/fifo_arb_pkg.sv | 14 +
 rtl/fifo_write_arbiter_if.sv | 33 +++
 rtl/rr_picker.sv | 31 +++
 rtl/fifo_write_arbiter.sv | 127 ++++++++++++
 tb/tb_fifo_write_arbiter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizes for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_MAX_BURST  = 8;
    localparam int unsigned DEF_CNT_WIDTH  = 16;

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Producer-side handshake and FIFO write-side signals of the write-port arbiter.
interface fifo_write_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
);

    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]                 req_last;
    logic [NUM_REQ-1:0]                 req_ready;
    logic                               wfull;
    logic                               winc;
    logic [DATA_WIDTH-1:0]              wdata;
    logic [NUM_REQ-1:0]                 grant;
    logic                               busy;
    logic [CNT_WIDTH-1:0]               stall_cnt;

    // Arbiter view.
    modport slave (
        input  req_valid, req_data, req_last, wfull,
        output req_ready, winc, wdata, grant, busy, stall_cnt
    );

    // Producers plus FIFO view.
    modport master (
        output req_valid, req_data, req_last, wfull,
        input  req_ready, winc, wdata, grant, busy, stall_cnt
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr, wrapping.
module rr_picker #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr_i,
    output logic [NUM_REQ-1:0]         pick_c_o,
    output logic                       any_req_c_o
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    int unsigned idx;

    always_comb begin
        pick_c_o    = '0;
        any_req_c_o = 1'b0;
        idx         = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = 32'(rr_ptr_i) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_req_c_o && req_i[PTR_W'(idx)]) begin
                pick_c_o[PTR_W'(idx)] = 1'b1;
                any_req_c_o           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-bounded sharing of the async FIFO write port among NUM_REQ producers.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned MAX_BURST  = DEF_MAX_BURST,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input logic                 clk,
    input logic                 rst_n,
    fifo_write_arbiter_if.slave arb_if
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned BCW   = $clog2(MAX_BURST + 1);

    arb_state_e           state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [BCW-1:0]       beat_cnt_q, beat_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    logic [NUM_REQ-1:0]    pick_c;
    logic                  any_req_c;
    logic                  own_valid_c;
    logic                  own_last_c;
    logic [DATA_WIDTH-1:0] own_data_c;
    logic [PTR_W-1:0]      own_idx_c;
    logic [PTR_W-1:0]      next_ptr_c;
    logic                  accept_c;
    logic                  stall_c;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_picker (
        .req_i       (arb_if.req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .pick_c_o    (pick_c),
        .any_req_c_o (any_req_c)
    );

    // Owner-side signals selected by the one-hot grant (all zero while idle).
    always_comb begin
        own_valid_c = 1'b0;
        own_last_c  = 1'b0;
        own_data_c  = '0;
        own_idx_c   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                own_valid_c = arb_if.req_valid[i];
                own_last_c  = arb_if.req_last[i];
                own_data_c  = arb_if.req_data[i];
                own_idx_c   = PTR_W'(i);
            end
        end
    end

    assign next_ptr_c = (own_idx_c == PTR_W'(NUM_REQ - 1)) ? '0 : own_idx_c + PTR_W'(1);
    assign accept_c   = (state_q == BUSY) & own_valid_c & ~arb_if.wfull;
    assign stall_c    = (state_q == BUSY) & own_valid_c &  arb_if.wfull;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next state: arbitrate in IDLE, count beats and release in BUSY.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        stall_cnt_d = stall_cnt_q;

        if (stall_c && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                if (any_req_c) begin
                    grant_d    = pick_c;
                    beat_cnt_d = '0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (!own_valid_c) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = next_ptr_c;
                end else if (accept_c) begin
                    beat_cnt_d = beat_cnt_q + BCW'(1);
                    if (own_last_c || (beat_cnt_q == BCW'(MAX_BURST - 1))) begin
                        state_d  = IDLE;
                        grant_d  = '0;
                        rr_ptr_d = next_ptr_c;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign arb_if.winc      = accept_c;
    assign arb_if.wdata     = own_data_c;
    assign arb_if.req_ready = grant_q & {NUM_REQ{~arb_if.wfull}};
    assign arb_if.grant     = grant_q;
    assign arb_if.busy      = (state_q == BUSY);
    assign arb_if.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized bench for fifo_write_arbiter against a per-cycle ownership model and per-producer scoreboard.
module tb_fifo_write_arbiter;

    localparam int unsigned DW    = 8;
    localparam int unsigned NR    = 4;
    localparam int unsigned MB    = 8;
    localparam int unsigned CW    = 16;
    localparam int unsigned DEPTH = 8;

    logic clk;
    logic rst_n;

    fifo_write_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .CNT_WIDTH(CW)) bus ();

    fifo_write_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .MAX_BURST  (MB),
        .CNT_WIDTH  (CW)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .arb_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: owner index (-1 when idle), next start index, beats in grant, stall count.
    int m_owner;
    int m_ptr;
    int m_beats;
    int m_stall;

    // Producers and FIFO occupancy.
    bit            pend    [NR];
    logic [DW-1:0] pdata   [NR];
    bit            plast   [NR];
    int            seq     [NR];
    int            exp_seq [NR];
    int            waitc   [NR];
    int            occ;
    int            mode;
    logic [NR-1:0] v;
    logic          wf;

    function automatic logic [DW-1:0] beat_word(input int p, input int s);
        return DW'(p * 64 + (s % 64));
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < NR; i++) begin
            if (!pend[i] && (mode == 1 || ($urandom % 3) == 0)) begin
                pend[i]  = 1'b1;
                pdata[i] = beat_word(i, seq[i]);
                seq[i]++;
                plast[i] = (mode == 1) ? 1'b0 : (($urandom % 4) == 0);
            end
            v[i] = pend[i] && (mode == 1 || ($urandom % 8) != 0);
            bus.req_data[i] = pdata[i];
            bus.req_last[i] = plast[i];
        end
        wf = (mode == 1) ? 1'b0 : ((occ >= DEPTH) || (($urandom % 16) == 0));
        bus.req_valid = v;
        bus.wfull     = wf;
    endtask

    task automatic model_release();
        m_ptr   = (m_owner + 1) % NR;
        m_owner = -1;
    endtask

    task automatic compare_and_update();
        logic [NR-1:0] exp_grant;
        logic [NR-1:0] exp_ready;
        logic          exp_winc;
        exp_grant = (m_owner >= 0) ? (NR'(1) << m_owner) : '0;
        exp_ready = wf ? '0 : exp_grant;
        exp_winc  = (m_owner >= 0) && v[m_owner] && !wf;

        check_eq("grant",     32'(bus.grant),     32'(exp_grant));
        check_eq("busy",      32'(bus.busy),      32'(m_owner >= 0));
        check_eq("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        check_eq("winc",      32'(bus.winc),      32'(exp_winc));
        check_eq("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
        check_eq("winc_while_full", 32'(bus.winc & bus.wfull), 32'(0));
        if (exp_winc) begin
            check_eq("wdata_order", 32'(bus.wdata), 32'(beat_word(m_owner, exp_seq[m_owner])));
        end

        if (m_owner < 0) begin
            for (int k = 0; k < NR; k++) begin
                int idx;
                idx = (m_ptr + k) % NR;
                if (v[idx]) begin
                    check_eq("fairness", 32'(waitc[idx] <= NR - 1), 32'(1));
                    waitc[idx] = 0;
                    for (int j = 0; j < NR; j++) begin
                        if (j != idx && v[j]) waitc[j]++;
                    end
                    m_owner = idx;
                    m_beats = 0;
                    break;
                end
            end
        end else if (v[m_owner] && !wf) begin
            m_beats++;
            exp_seq[m_owner]++;
            pend[m_owner] = 1'b0;
            occ++;
            if (plast[m_owner] || m_beats == MB) model_release();
        end else if (!v[m_owner]) begin
            model_release();
        end else if (m_stall < (1 << CW) - 1) begin
            m_stall++;
        end

        for (int i = 0; i < NR; i++) begin
            if (!v[i]) waitc[i] = 0;
        end

        if (mode == 1) occ = 0;
        else if (occ > 0 && ($urandom % 3) != 0) occ--;
    endtask

    task automatic step(input bit release_rst);
        @(negedge clk);
        if (release_rst) rst_n = 1'b1;
        drive_inputs();
        #1;
        compare_and_update();
    endtask

    initial begin
        bit found;
        n_cmp   = 0;
        n_err   = 0;
        m_owner = -1;
        m_ptr   = 0;
        m_beats = 0;
        m_stall = 0;
        occ     = 0;
        mode    = 0;
        v       = '0;
        wf      = 1'b0;
        for (int i = 0; i < NR; i++) begin
            pend[i] = 1'b0; pdata[i] = '0; plast[i] = 1'b0;
            seq[i] = 0; exp_seq[i] = 0; waitc[i] = 0;
        end
        rst_n         = 1'b0;
        bus.req_valid = '1;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.wfull     = 1'b0;

        // Held in reset with requests pending: nothing granted, nothing written.
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_grant",     32'(bus.grant),     32'(0));
        check_eq("rst_busy",      32'(bus.busy),      32'(0));
        check_eq("rst_winc",      32'(bus.winc),      32'(0));
        check_eq("rst_req_ready", 32'(bus.req_ready), 32'(0));
        check_eq("rst_stall_cnt", 32'(bus.stall_cnt), 32'(0));
        bus.req_valid = '0;

        step(1'b1);
        repeat (3000) step(1'b0);

        // Saturated traffic: all producers valid, no packet ends, FIFO never full.
        mode = 1;
        repeat (200) step(1'b0);

        // Find a grant with three beats taken, then reset before the fourth.
        found = 1'b0;
        for (int t = 0; t < 200 && !found; t++) begin
            step(1'b0);
            if (m_owner >= 0 && m_beats == 3) found = 1'b1;
        end
        check_eq("burst_wait_timeout", 32'(found), 32'(1));

        @(negedge clk);
        drive_inputs();
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_grant",     32'(bus.grant),     32'(0));
        check_eq("midrst_winc",      32'(bus.winc),      32'(0));
        check_eq("midrst_stall_cnt", 32'(bus.stall_cnt), 32'(0));
        check_eq("midrst_busy",      32'(bus.busy),      32'(0));
        m_owner = -1;
        m_ptr   = 0;
        m_beats = 0;
        m_stall = 0;
        for (int i = 0; i < NR; i++) waitc[i] = 0;
        @(posedge clk);

        // Fresh arbitration after reset starts from producer 0.
        step(1'b1);
        step(1'b0);
        check_eq("post_rst_grant", 32'(bus.grant), 32'(4'b0001));
        repeat (100) step(1'b0);

        mode = 0;
        repeat (1000) step(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
